// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - loadable down-counter with one-cycle expiry pulse
//
// Purpose:
//   Accepts a start value over a valid/ready load handshake and counts it down
//   to zero while enable is high. It pulses done for one cycle on expiry. It
//   serves as a one-shot or periodic timer for control FSMs.
//
// Optional feature (macro COUNTDOWN_RELOAD_EN):
//   Adds the reload_en input and a reload register that holds the last
//   accepted load value. At expiry with reload_en=1 and a non-zero reload
//   value, the count restarts from that value instead of stopping.
//
// Ports:
//   clock       in   rising-edge clock
//   reset       in   synchronous, active-high reset
//   load_valid  in   load_value is valid this cycle
//   load_ready  out  block can accept a load (combinational)
//   load_value  in   [BITS] start value, sampled on handshake
//   enable      in   decrement permission while running; low pauses
//   abort       in   cancel a running count; blocks loads while idle
//   reload_en   in   (COUNTDOWN_RELOAD_EN only) restart from reload value at expiry
//   count       out  [BITS] current count, registered
//   busy        out  count in progress, registered
//   done        out  one-cycle expiry pulse, registered

module countdown_timer #(
    parameter int BITS = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            load_valid,
    output logic            load_ready,
    input  logic [BITS-1:0] load_value,
    input  logic            enable,
    input  logic            abort,
`ifdef COUNTDOWN_RELOAD_EN
    input  logic            reload_en,
`endif
    output logic [BITS-1:0] count,
    output logic            busy,
    output logic            done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [BITS-1:0] ZERO = '0;
    localparam logic [BITS-1:0] ONE  = BITS'(1);

    state_t state;

`ifdef COUNTDOWN_RELOAD_EN
    logic [BITS-1:0] reload_value;
`endif

    // Loads are only taken while idle. Abort in idle also blocks them, so a
    // cancel and a fresh load cannot race in the same cycle.
    assign load_ready = (state == IDLE) && !abort;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            count <= ZERO;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef COUNTDOWN_RELOAD_EN
            reload_value <= ZERO;
`endif
        end else begin
            // done is a single-cycle pulse. Every path that does not raise it
            // lets it fall.
            done <= 1'b0;

            case (state)
                IDLE: begin
                    if (load_valid && load_ready) begin
`ifdef COUNTDOWN_RELOAD_EN
                        reload_value <= load_value;
`endif
                        if (load_value != ZERO) begin
                            count <= load_value;
                            busy  <= 1'b1;
                            state <= RUN;
                        end else begin
                            // A zero load expires immediately without
                            // entering RUN.
                            count <= ZERO;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end

                RUN: begin
                    if (abort) begin
                        // Cancellation beats both enable and expiry. It
                        // never produces done.
                        count <= ZERO;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (enable) begin
                        if (count == ONE) begin
                            done <= 1'b1;
`ifdef COUNTDOWN_RELOAD_EN
                            if (reload_en && (reload_value != ZERO)) begin
                                count <= reload_value;
                            end else begin
                                count <= ZERO;
                                busy  <= 1'b0;
                                state <= IDLE;
                            end
`else
                            count <= ZERO;
                            busy  <= 1'b0;
                            state <= IDLE;
`endif
                        end else if (count == ZERO) begin
                            // RUN is never entered with zero, so this branch
                            // is unreachable. Falling back to IDLE keeps
                            // count from ever wrapping.
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            count <= count - ONE;
                        end
                    end
                    // enable low: count, busy and state hold.
                end

                default: begin
                    state <= IDLE;
                    count <= ZERO;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - self-checking bench for countdown_timer

module tb_countdown_timer;

    localparam int BITS = 8;

    logic            clock;
    logic            reset;
    logic            load_valid;
    logic            load_ready;
    logic [BITS-1:0] load_value;
    logic            enable;
    logic            abort;
    logic            reload_en;
    logic [BITS-1:0] count;
    logic            busy;
    logic            done;

    int n_cmp;
    int n_err;

    // Reference state: remaining ticks, whether a count is live, the expiry
    // pulse and the last accepted load.
    int m_count;
    bit m_busy;
    bit m_done;
    int m_reload;

    countdown_timer #(.BITS(BITS)) dut (
        .clock      (clock),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_value (load_value),
        .enable     (enable),
        .abort      (abort),
`ifdef COUNTDOWN_RELOAD_EN
        .reload_en  (reload_en),
`endif
        .count      (count),
        .busy       (busy),
        .done       (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        load_valid = 1'b0;
        load_value = '0;
        enable     = 1'b0;
        abort      = 1'b0;
        reload_en  = 1'b0;
    endtask

    // Advances the reference model by one clock edge.
    task automatic model_step(input bit r, input bit lv, input int lval,
                              input bit en, input bit ab, input bit rl);
        if (r) begin
            m_count = 0; m_busy = 0; m_done = 0; m_reload = 0;
        end else begin
            m_done = 0;
            if (!m_busy) begin
                if (lv && !ab) begin
                    m_reload = lval;
                    m_count  = lval;
                    m_busy   = (lval != 0);
                    m_done   = (lval == 0);
                end
            end else if (ab) begin
                m_count = 0;
                m_busy  = 0;
            end else if (en) begin
                m_count = m_count - 1;
                if (m_count == 0) begin
                    m_done = 1;
`ifdef COUNTDOWN_RELOAD_EN
                    if (rl && m_reload != 0) m_count = m_reload;
                    else m_busy = 0;
`else
                    m_busy = 0;
`endif
                end
            end
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_cmp++; if (count !== 8'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if (load_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", load_ready); end
        tick();
    endtask

    task automatic test_load5();
        int exp_c[6] = '{5, 4, 3, 2, 1, 0};
        bit exp_b[6] = '{1, 1, 1, 1, 1, 0};
        bit exp_d[6] = '{0, 0, 0, 0, 0, 1};
        idle_inputs();
        enable = 1'b1;
        load_valid = 1'b1;
        load_value = 8'd5;
        for (int i = 0; i < 6; i++) begin
            tick();
            load_valid = 1'b0;
            n_cmp++; if (count !== exp_c[i][BITS-1:0]) begin n_err++; $display("FAIL load5_count[%0d] got %0d want %0d", i, count, exp_c[i]); end
            n_cmp++; if (busy !== exp_b[i]) begin n_err++; $display("FAIL load5_busy[%0d] got %b want %b", i, busy, exp_b[i]); end
            n_cmp++; if (done !== exp_d[i]) begin n_err++; $display("FAIL load5_done[%0d] got %b want %b", i, done, exp_d[i]); end
        end
        tick();
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL load5_done_fall got %b want 0", done); end
        n_cmp++; if (count !== 8'd0) begin n_err++; $display("FAIL load5_nowrap got %0d want 0", count); end
    endtask

    task automatic test_pause();
        bit en_seq[6] = '{1, 0, 0, 1, 1, 1};
        int exp_c[6]  = '{3, 3, 3, 2, 1, 0};
        int pulses = 0;
        idle_inputs();
        load_valid = 1'b1;
        load_value = 8'd4;
        tick();
        load_valid = 1'b0;
        n_cmp++; if (count !== 8'd4) begin n_err++; $display("FAIL pause_load got %0d want 4", count); end
        for (int i = 0; i < 6; i++) begin
            enable = en_seq[i];
            tick();
            if (done) pulses++;
            n_cmp++; if (count !== exp_c[i][BITS-1:0]) begin n_err++; $display("FAIL pause_count[%0d] got %0d want %0d", i, count, exp_c[i]); end
        end
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL pause_done_end got %b want 1", done); end
        n_cmp++; if (pulses !== 1) begin n_err++; $display("FAIL pause_pulses got %0d want 1", pulses); end
        idle_inputs();
        tick();
    endtask

    task automatic test_abort();
        int pulses = 0;
        idle_inputs();
        load_valid = 1'b1;
        load_value = 8'd200;
        tick();
        load_valid = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done) pulses++;
        end
        n_cmp++; if (count !== 8'd197) begin n_err++; $display("FAIL abort_pre got %0d want 197", count); end
        abort = 1'b1;
        tick();
        if (done) pulses++;
        n_cmp++; if (count !== 8'd0) begin n_err++; $display("FAIL abort_count got %0d want 0", count); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got %b want 0", busy); end
        load_valid = 1'b1;
        load_value = 8'd9;
        #1;
        n_cmp++; if (load_ready !== 1'b0) begin n_err++; $display("FAIL abort_ready got %b want 0", load_ready); end
        tick();
        if (done) pulses++;
        n_cmp++; if (busy !== 1'b0 || count !== 8'd0) begin n_err++; $display("FAIL abort_blocked got busy=%b count=%0d want 0/0", busy, count); end
        n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL abort_nodone got %0d pulses want 0", pulses); end
        idle_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        idle_inputs();
        enable = 1'b1;
        load_valid = 1'b1;
        load_value = 8'd0;
        tick();
        n_cmp++; if (done !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL zero_load got done=%b busy=%b want 1/0", done, busy); end
        n_cmp++; if (load_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready got %b want 1", load_ready); end
        load_value = 8'd3;
        tick();
        load_valid = 1'b0;
        n_cmp++; if (count !== 8'd3 || busy !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL b2b_load got count=%0d busy=%b done=%b want 3/1/0", count, busy, done); end
        abort = 1'b1;
        tick();
        idle_inputs();
        tick();
    endtask

`ifdef COUNTDOWN_RELOAD_EN
    task automatic test_reload();
        int exp_c[7] = '{3, 2, 1, 3, 2, 1, 3};
        bit exp_d[7] = '{0, 0, 0, 1, 0, 0, 1};
        idle_inputs();
        enable = 1'b1;
        reload_en = 1'b1;
        load_valid = 1'b1;
        load_value = 8'd3;
        for (int i = 0; i < 7; i++) begin
            tick();
            load_valid = 1'b0;
            n_cmp++; if (count !== exp_c[i][BITS-1:0] || done !== exp_d[i] || busy !== 1'b1) begin
                n_err++; $display("FAIL reload[%0d] got count=%0d done=%b busy=%b want %0d/%b/1", i, count, done, busy, exp_c[i], exp_d[i]);
            end
        end
        reload_en = 1'b0;
        tick(); tick(); tick();
        n_cmp++; if (count !== 8'd0 || busy !== 1'b0 || done !== 1'b1) begin
            n_err++; $display("FAIL reload_stop got count=%0d busy=%b done=%b want 0/0/1", count, busy, done);
        end
        idle_inputs();
        tick();
    endtask
`endif

    task automatic test_random();
        bit r, lv, en, ab, rl;
        int lval;
        idle_inputs();
        reset = 1'b1;
        tick();
        model_step(1, 0, 0, 0, 0, 0);
        reset = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            r   = ($urandom_range(0, 99) == 0);
            lv  = ($urandom_range(0, 3) == 0);
            lval = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 6);
            en  = ($urandom_range(0, 3) != 0);
            ab  = ($urandom_range(0, 29) == 0);
`ifdef COUNTDOWN_RELOAD_EN
            rl  = ($urandom_range(0, 1) == 1);
`else
            rl  = 1'b0;
`endif
            reset = r; load_valid = lv; load_value = lval[BITS-1:0];
            enable = en; abort = ab; reload_en = rl;
            #1;
            n_cmp++; if (load_ready !== (!m_busy && !ab)) begin n_err++; $display("FAIL rand_ready[%0d] got %b want %b", i, load_ready, !m_busy && !ab); end
            tick();
            model_step(r, lv, lval, en, ab, rl);
            n_cmp++; if (count !== m_count[BITS-1:0] || busy !== m_busy || done !== m_done) begin
                n_err++; $display("FAIL rand_state[%0d] got count=%0d busy=%b done=%b want %0d/%b/%b", i, count, busy, done, m_count, m_busy, m_done);
            end
        end
        idle_inputs();
        reset = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_load5();
        test_pause();
        test_abort();
        test_back_to_back();
`ifdef COUNTDOWN_RELOAD_EN
        test_reload();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
